// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Groups the sequencer's handshake and bus signals:
//   cmd_*  : command channel from decode (valid/ready)
//   alu_*  : operand/op/strobe to the ALU and its registered result/flags back
//   rsp_*  : tagged response channel to writeback (valid/ready)
//   cond_flags, busy : status outputs
// Modports:
//   slave  : the sequencer's view
//   master : the surrounding environment (decode, ALU, writeback)
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 8,
    parameter int TAG_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [TAG_W-1:0]  cmd_tag;

    logic              alu_valid;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_overflow;
    logic              alu_eq;
    logic              alu_lt;
    logic              alu_gt;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_res;
    logic [5:0]        rsp_flags;
    logic [TAG_W-1:0]  rsp_tag;

    logic [2:0]        cond_flags;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output alu_valid, alu_op, alu_a, alu_b,
        input  alu_res, alu_carry, alu_overflow, alu_eq, alu_lt, alu_gt, alu_zero,
        output rsp_valid, rsp_res, rsp_flags, rsp_tag,
        input  rsp_ready,
        output cond_flags, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  alu_valid, alu_op, alu_a, alu_b,
        output alu_res, alu_carry, alu_overflow, alu_eq, alu_lt, alu_gt, alu_zero,
        input  rsp_valid, rsp_res, rsp_flags, rsp_tag,
        output rsp_ready,
        input  cond_flags, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Front-end issuer and result collector for the 64-bit ALU. Commands from
// decode are queued in a DEPTH-entry FIFO, issued to the ALU one at a time,
// and the ALU's registered result/flags are returned to writeback with the
// command's tag. Responses come back strictly in command order.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : alu_sequencer_if.slave (cmd_*, alu_*, rsp_*, cond_flags, busy)
//
// Optional feature (macro ALU_SEQ_COND_FLAGS_EN):
//   defined     : cond_flags is a sticky {gt, lt, eq} register, loaded when a
//                 UCMP (8'h08) or CMP (8'h0E) result is captured.
//   not defined : cond_flags is tied to 3'b000.
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 8,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            cmd_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    state_t            state_reg;
    state_t            state_next;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_res_reg;
    logic [5:0]        rsp_flags_reg;
    logic [TAG_W-1:0]  rsp_tag_reg;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------ FIFO
    // Ready comes from the registered count only, so a full FIFO never
    // accepts in the same cycle it pops.
    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    assign push      = bus.cmd_valid && !full;
    assign pop       = (state_reg == CAPTURE);
    assign cmd_entry = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_tag};
    assign head      = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= cmd_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!empty) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;   // ALU registers its result here
            CAPTURE: state_next = HOLD;
            HOLD: begin
                // count already reflects the pop done on entry to HOLD; a
                // push in this same cycle is not visible yet.
                if (rsp_valid_reg && bus.rsp_ready) begin
                    state_next = empty ? IDLE : ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_res_reg   <= '0;
            rsp_flags_reg <= '0;
            rsp_tag_reg   <= '0;
        end else if (state_reg == CAPTURE) begin
            rsp_valid_reg <= 1'b1;
            rsp_res_reg   <= bus.alu_res;
            rsp_flags_reg <= {bus.alu_zero, bus.alu_gt, bus.alu_lt,
                              bus.alu_eq, bus.alu_overflow, bus.alu_carry};
            rsp_tag_reg   <= head.tag;
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

`ifdef ALU_SEQ_COND_FLAGS_EN
    localparam logic [OP_W-1:0] OP_UCMP = OP_W'(8'h08);
    localparam logic [OP_W-1:0] OP_CMP  = OP_W'(8'h0E);

    logic [2:0] cond_flags_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cond_flags_reg <= 3'b000;
        end else if ((state_reg == CAPTURE) &&
                     ((head.op == OP_UCMP) || (head.op == OP_CMP))) begin
            cond_flags_reg <= {bus.alu_gt, bus.alu_lt, bus.alu_eq};
        end
    end

    assign bus.cond_flags = cond_flags_reg;
`else
    assign bus.cond_flags = 3'b000;
`endif

    // --------------------------------------------------------------- outputs
    assign bus.cmd_ready = !full;
    assign bus.alu_valid = (state_reg == ISSUE);
    assign bus.alu_op    = head.op;
    assign bus.alu_a     = head.a;
    assign bus.alu_b     = head.b;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_res   = rsp_res_reg;
    assign bus.rsp_flags = rsp_flags_reg;
    assign bus.rsp_tag   = rsp_tag_reg;
    assign bus.busy      = !empty || (state_reg != IDLE);
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Front-end issuer and result collector for the 64-bit ALU.
- Accepts operation commands from decode through a valid/ready handshake and queues them in a small FIFO.
- Drives the ALU operand/op/valid inputs one operation at a time, captures its registered result and flags one cycle later, and presents a tagged response to writeback through a valid/ready handshake.

Parameters:
- DATA_W, 64, operand/result width; matches ALU DATA_W.
- OP_W, 8, opcode width; matches ALU OP_W.
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TAG_W, 4, width of the command tag carried through to the response.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_op  in  OP_W  ALU opcode.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_tag  in  TAG_W  requester tag.
- alu_valid  out  1  ALU operation strobe.
- alu_op  out  OP_W  opcode to ALU.
- alu_a  out  DATA_W  operand A to ALU.
- alu_b  out  DATA_W  operand B to ALU.
- alu_res  in  DATA_W  ALU result.
- alu_carry, alu_overflow, alu_eq, alu_lt, alu_gt, alu_zero  in  1 each  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  writeback accepts.
- rsp_res  out  DATA_W  captured result.
- rsp_flags  out  6  {zero, gt, lt, eq, overflow, carry}.
- rsp_tag  out  TAG_W  tag of the completed command.
- cond_flags  out  3  sticky {gt, lt, eq}; see Optional Feature.
- busy  out  1  FIFO non-empty or state not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO pointers and count cleared.
  - State set to IDLE.
  - alu_valid, rsp_valid, rsp_res, rsp_flags, rsp_tag and cond_flags all 0.
  - cmd_ready is 1 after reset.
  - An in-flight operation is dropped and never responded to.
  - The ALU's own reset is driven by the parent and is not controlled here.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = !full, derived from registered count only; no same-cycle bypass when full.
  - Pointers wrap modulo DEPTH.
  - Pop occurs on the CAPTURE→HOLD edge.
- ALU outputs:
  - alu_op, alu_a and alu_b always reflect the FIFO head entry.
  - alu_valid = (state == ISSUE), high for exactly one cycle per operation.
- States:
  - IDLE: FIFO non-empty → ISSUE.
  - ISSUE: unconditional → CAPTURE. The ALU registers its result on this edge.
  - CAPTURE: alu_res and flags are valid this cycle. On the edge, load rsp_res, rsp_flags, and rsp_tag (from head), pop the FIFO, set rsp_valid=1, go to HOLD.
  - HOLD: on rsp_valid && rsp_ready, clear rsp_valid. Then go to ISSUE if the FIFO is non-empty (after any same-cycle push is not counted), otherwise IDLE.
- Latency:
  - Acceptance edge E0 → rsp_valid high after E3 (3 cycles) when idle.
  - Back-to-back throughput is one op per 3 cycles with rsp_ready held high.
- Capacity: DEPTH queued commands + 1 held response.
- Ordering: responses strictly in command order.
- Response stability: rsp_* stable while rsp_valid && !rsp_ready.
- Opcode handling: opcodes are passed through unchecked. Unknown opcodes and divide-by-zero return whatever the ALU produces.
- Simultaneous push and pop: allowed when not full; count is unchanged.

Optional Feature:
- Macro: ALU_SEQ_COND_FLAGS_EN.
- Defined: on the CAPTURE edge, if the head opcode is 8'h08 (UCMP) or 8'h0E (CMP), load cond_flags <= {alu_gt, alu_lt, alu_eq}. Otherwise cond_flags holds its value. Cleared only by reset.
- Not defined: cond_flags tied to 3'b000 and no register is inferred.

Test Plan:
- Reset then push ADD (8'h01), a=5, b=7, tag=3, rsp_ready=1 → alu_valid pulses 1 cycle; rsp_valid 3 cycles after acceptance; rsp_res=12, rsp_flags=6'b000000, rsp_tag=3.
- ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1 → rsp_res=0, carry=1, zero=1 (rsp_flags=6'b100001).
- rsp_ready=0, push 6 commands with tags 0..5 → exactly 5 accepted (cmd_ready low after tag 4); release rsp_ready → tags 0,1,2,3,4 returned in order; then tag 5 accepted.
- UCMP (8'h08) a=3, b=9, then CMP (8'h0E) a=-1, b=2 → eq/lt/gt in rsp_flags = lt for both; with ALU_SEQ_COND_FLAGS_EN, cond_flags=3'b010 after each and held across a following ADD; without the macro, cond_flags=0 throughout.
- Assert rst low during CAPTURE with 2 commands queued → rsp_valid, alu_valid and busy drop immediately; cmd_ready=1 after release; no response is ever produced for the dropped commands.
- rsp_ready toggled every other cycle over 4 SUB (8'h02) ops → rsp_* never change while rsp_valid && !rsp_ready; each rsp_res equals a−b.
